// File: rtl/axi4_reg_slice.sv
//==============================================================================
// Module      : axi4_reg_slice
// Description : Full AXI4 register slice. Each of the five channels passes
//               through its own 2-entry skid buffer, so every VALID, READY
//               and payload seen on either side comes straight from a flop.
//               Optional write-burst checker and AW/W flow gating, enabled by
//               defining the macro AXI4_SLICE_BURST_CHECK_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

// Two-entry skid buffer: head entry drives the output, tail catches the beat
// that arrives while the head is stalled.
module axi4_reg_slice_skid #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_data
);

   logic [1:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic [WIDTH-1:0] tail_q, tail_d;
   logic             valid_q, valid_d;
   logic             ready_q, ready_d;
   logic             push, pop;

   // Next-state for occupancy and entries; READY/VALID precomputed from next count
   always_comb begin
      push   = i_valid & ready_q;
      pop    = valid_q & i_ready;
      cnt_d  = cnt_q;
      head_d = head_q;
      tail_d = tail_q;
      case ({push, pop})
         2'b10: begin
            if (cnt_q == 2'd0) head_d = i_data;
            else               tail_d = i_data;
            cnt_d = cnt_q + 2'd1;
         end
         2'b01: begin
            if (cnt_q == 2'd2) head_d = tail_q;
            cnt_d = cnt_q - 2'd1;
         end
         2'b11: begin
            // Count is unchanged; the new beat goes behind whatever remains.
            if (cnt_q == 2'd1) begin
               head_d = i_data;
            end else begin
               head_d = tail_q;
               tail_d = i_data;
            end
         end
         default: ;
      endcase
      valid_d = (cnt_d != 2'd0);
      ready_d = (cnt_d != 2'd2);
   end

   // State registers, cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= 2'd0;
         head_q  <= '0;
         tail_q  <= '0;
         valid_q <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         valid_q <= valid_d;
         ready_q <= ready_d;
      end
   end

   assign o_ready = ready_q;
   assign o_valid = valid_q;
   assign o_data  = head_q;

endmodule

module axi4_reg_slice #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   // upstream write address
   input  logic [ADDR_WIDTH-1:0] s_AWADDR,
   input  logic [7:0]            s_AWLEN,
   input  logic [2:0]            s_AWSIZE,
   input  logic                  s_AWVALID,
   output logic                  s_AWREADY,
   // upstream write data
   input  logic [DATA_WIDTH-1:0] s_WDATA,
   input  logic                  s_WLAST,
   input  logic                  s_WVALID,
   output logic                  s_WREADY,
   // upstream write response
   output logic [1:0]            s_BRESP,
   output logic                  s_BVALID,
   input  logic                  s_BREADY,
   // upstream read address
   input  logic [ADDR_WIDTH-1:0] s_ARADDR,
   input  logic [7:0]            s_ARLEN,
   input  logic [2:0]            s_ARSIZE,
   input  logic                  s_ARVALID,
   output logic                  s_ARREADY,
   // upstream read data
   output logic [DATA_WIDTH-1:0] s_RDATA,
   output logic [1:0]            s_RRESP,
   output logic                  s_RLAST,
   output logic                  s_RVALID,
   input  logic                  s_RREADY,
   // downstream write address
   output logic [ADDR_WIDTH-1:0] m_AWADDR,
   output logic [7:0]            m_AWLEN,
   output logic [2:0]            m_AWSIZE,
   output logic                  m_AWVALID,
   input  logic                  m_AWREADY,
   // downstream write data
   output logic [DATA_WIDTH-1:0] m_WDATA,
   output logic                  m_WLAST,
   output logic                  m_WVALID,
   input  logic                  m_WREADY,
   // downstream write response
   input  logic [1:0]            m_BRESP,
   input  logic                  m_BVALID,
   output logic                  m_BREADY,
   // downstream read address
   output logic [ADDR_WIDTH-1:0] m_ARADDR,
   output logic [7:0]            m_ARLEN,
   output logic [2:0]            m_ARSIZE,
   output logic                  m_ARVALID,
   input  logic                  m_ARREADY,
   // downstream read data
   input  logic [DATA_WIDTH-1:0] m_RDATA,
   input  logic [1:0]            m_RRESP,
   input  logic                  m_RLAST,
   input  logic                  m_RVALID,
   output logic                  m_RREADY,
   // sticky write-burst length violation
   output logic                  burst_err
);

   localparam int AX_W = ADDR_WIDTH + 8 + 3;
   localparam int W_W  = DATA_WIDTH + 1;
   localparam int R_W  = DATA_WIDTH + 3;

   logic aw_buf_ready, w_buf_ready;
   logic aw_gate, w_gate;

   axi4_reg_slice_skid #(.WIDTH(AX_W)) u_aw (
      .clk     (ACLK),
      .rst     (ARESET),
      .i_valid (s_AWVALID & aw_gate),
      .o_ready (aw_buf_ready),
      .i_data  ({s_AWADDR, s_AWLEN, s_AWSIZE}),
      .o_valid (m_AWVALID),
      .i_ready (m_AWREADY),
      .o_data  ({m_AWADDR, m_AWLEN, m_AWSIZE})
   );

   axi4_reg_slice_skid #(.WIDTH(W_W)) u_w (
      .clk     (ACLK),
      .rst     (ARESET),
      .i_valid (s_WVALID & w_gate),
      .o_ready (w_buf_ready),
      .i_data  ({s_WDATA, s_WLAST}),
      .o_valid (m_WVALID),
      .i_ready (m_WREADY),
      .o_data  ({m_WDATA, m_WLAST})
   );

   axi4_reg_slice_skid #(.WIDTH(2)) u_b (
      .clk     (ACLK),
      .rst     (ARESET),
      .i_valid (m_BVALID),
      .o_ready (m_BREADY),
      .i_data  (m_BRESP),
      .o_valid (s_BVALID),
      .i_ready (s_BREADY),
      .o_data  (s_BRESP)
   );

   axi4_reg_slice_skid #(.WIDTH(AX_W)) u_ar (
      .clk     (ACLK),
      .rst     (ARESET),
      .i_valid (s_ARVALID),
      .o_ready (s_ARREADY),
      .i_data  ({s_ARADDR, s_ARLEN, s_ARSIZE}),
      .o_valid (m_ARVALID),
      .i_ready (m_ARREADY),
      .o_data  ({m_ARADDR, m_ARLEN, m_ARSIZE})
   );

   axi4_reg_slice_skid #(.WIDTH(R_W)) u_r (
      .clk     (ACLK),
      .rst     (ARESET),
      .i_valid (m_RVALID),
      .o_ready (m_RREADY),
      .i_data  ({m_RDATA, m_RRESP, m_RLAST}),
      .o_valid (s_RVALID),
      .i_ready (s_RREADY),
      .o_data  ({s_RDATA, s_RRESP, s_RLAST})
   );

   assign s_AWREADY = aw_buf_ready & aw_gate;
   assign s_WREADY  = w_buf_ready & w_gate;

`ifdef AXI4_SLICE_BURST_CHECK_EN
   logic [7:0] len_mem_q [4];
   logic [7:0] len_mem_d [4];
   logic [1:0] wr_ptr_q, wr_ptr_d;
   logic [1:0] rd_ptr_q, rd_ptr_d;
   logic [2:0] qcnt_q, qcnt_d;
   logic [7:0] wcnt_q, wcnt_d;
   logic       err_q, err_d;
   logic       aw_gate_q, aw_gate_d;
   logic       w_gate_q, w_gate_d;
   logic       aw_hs, w_hs, len_match, burst_end;

   // AWLEN queue bookkeeping, beat counting and length/WLAST agreement
   always_comb begin
      aw_hs     = s_AWVALID & s_AWREADY;
      w_hs      = s_WVALID & s_WREADY;
      // wcnt_q beats already taken, so this beat is the last one when wcnt_q == AWLEN
      len_match = (wcnt_q == len_mem_q[rd_ptr_q]);
      burst_end = w_hs & (s_WLAST | len_match);
      len_mem_d = len_mem_q;
      if (aw_hs) len_mem_d[wr_ptr_q] = s_AWLEN;
      wr_ptr_d  = wr_ptr_q + {1'b0, aw_hs};
      rd_ptr_d  = rd_ptr_q + {1'b0, burst_end};
      qcnt_d    = qcnt_q + {2'b00, aw_hs} - {2'b00, burst_end};
      if (burst_end)  wcnt_d = 8'd0;
      else if (w_hs)  wcnt_d = wcnt_q + 8'd1;
      else            wcnt_d = wcnt_q;
      err_d     = err_q | (w_hs & (s_WLAST ^ len_match));
      aw_gate_d = (qcnt_d != 3'd4);
      w_gate_d  = (qcnt_d != 3'd0);
   end

   // Checker registers; gates stay closed during reset
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         for (int i = 0; i < 4; i++) len_mem_q[i] <= 8'd0;
         wr_ptr_q  <= 2'd0;
         rd_ptr_q  <= 2'd0;
         qcnt_q    <= 3'd0;
         wcnt_q    <= 8'd0;
         err_q     <= 1'b0;
         aw_gate_q <= 1'b0;
         w_gate_q  <= 1'b0;
      end else begin
         len_mem_q <= len_mem_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         qcnt_q    <= qcnt_d;
         wcnt_q    <= wcnt_d;
         err_q     <= err_d;
         aw_gate_q <= aw_gate_d;
         w_gate_q  <= w_gate_d;
      end
   end

   assign aw_gate   = aw_gate_q;
   assign w_gate    = w_gate_q;
   assign burst_err = err_q;
`else
   assign aw_gate   = 1'b1;
   assign w_gate    = 1'b1;
   assign burst_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_axi4_reg_slice.sv
//==============================================================================
// Module      : tb_axi4_reg_slice
// Description : Self-checking bench for axi4_reg_slice. Channels are indexed
//               0=AW 1=W 2=AR 3=B 4=R; each has a FIFO reference model of
//               accepted beats. Burst checker tests need
//               AXI4_SLICE_BURST_CHECK_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_axi4_reg_slice;

   logic ACLK = 1'b0;
   logic ARESET = 1'b1;

   always #5 ACLK = ~ACLK;

   // stimulus per channel
   logic        in_v  [5];
   logic [63:0] in_d  [5];
   logic        out_r [5];

   // DUT outputs
   wire        s_AWREADY, s_WREADY, s_ARREADY, m_BREADY, m_RREADY;
   wire        m_AWVALID, m_WVALID, m_ARVALID, s_BVALID, s_RVALID;
   wire [15:0] m_AWADDR, m_ARADDR;
   wire [7:0]  m_AWLEN, m_ARLEN;
   wire [2:0]  m_AWSIZE, m_ARSIZE;
   wire [31:0] m_WDATA, s_RDATA;
   wire        m_WLAST, s_RLAST;
   wire [1:0]  s_BRESP, s_RRESP;
   wire        burst_err;

   logic        obs_rdy [5];
   logic        obs_vld [5];
   logic [63:0] obs_dat [5];

   assign obs_rdy[0] = s_AWREADY;
   assign obs_rdy[1] = s_WREADY;
   assign obs_rdy[2] = s_ARREADY;
   assign obs_rdy[3] = m_BREADY;
   assign obs_rdy[4] = m_RREADY;
   assign obs_vld[0] = m_AWVALID;
   assign obs_vld[1] = m_WVALID;
   assign obs_vld[2] = m_ARVALID;
   assign obs_vld[3] = s_BVALID;
   assign obs_vld[4] = s_RVALID;
   assign obs_dat[0] = {37'd0, m_AWADDR, m_AWLEN, m_AWSIZE};
   assign obs_dat[1] = {31'd0, m_WDATA, m_WLAST};
   assign obs_dat[2] = {37'd0, m_ARADDR, m_ARLEN, m_ARSIZE};
   assign obs_dat[3] = {62'd0, s_BRESP};
   assign obs_dat[4] = {29'd0, s_RDATA, s_RRESP, s_RLAST};

   axi4_reg_slice #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
      .ACLK      (ACLK),
      .ARESET    (ARESET),
      .s_AWADDR  (in_d[0][26:11]),
      .s_AWLEN   (in_d[0][10:3]),
      .s_AWSIZE  (in_d[0][2:0]),
      .s_AWVALID (in_v[0]),
      .s_AWREADY (s_AWREADY),
      .s_WDATA   (in_d[1][32:1]),
      .s_WLAST   (in_d[1][0]),
      .s_WVALID  (in_v[1]),
      .s_WREADY  (s_WREADY),
      .s_BRESP   (s_BRESP),
      .s_BVALID  (s_BVALID),
      .s_BREADY  (out_r[3]),
      .s_ARADDR  (in_d[2][26:11]),
      .s_ARLEN   (in_d[2][10:3]),
      .s_ARSIZE  (in_d[2][2:0]),
      .s_ARVALID (in_v[2]),
      .s_ARREADY (s_ARREADY),
      .s_RDATA   (s_RDATA),
      .s_RRESP   (s_RRESP),
      .s_RLAST   (s_RLAST),
      .s_RVALID  (s_RVALID),
      .s_RREADY  (out_r[4]),
      .m_AWADDR  (m_AWADDR),
      .m_AWLEN   (m_AWLEN),
      .m_AWSIZE  (m_AWSIZE),
      .m_AWVALID (m_AWVALID),
      .m_AWREADY (out_r[0]),
      .m_WDATA   (m_WDATA),
      .m_WLAST   (m_WLAST),
      .m_WVALID  (m_WVALID),
      .m_WREADY  (out_r[1]),
      .m_BRESP   (in_d[3][1:0]),
      .m_BVALID  (in_v[3]),
      .m_BREADY  (m_BREADY),
      .m_ARADDR  (m_ARADDR),
      .m_ARLEN   (m_ARLEN),
      .m_ARSIZE  (m_ARSIZE),
      .m_ARVALID (m_ARVALID),
      .m_ARREADY (out_r[2]),
      .m_RDATA   (in_d[4][34:3]),
      .m_RRESP   (in_d[4][2:1]),
      .m_RLAST   (in_d[4][0]),
      .m_RVALID  (in_v[4]),
      .m_RREADY  (m_RREADY),
      .burst_err (burst_err)
   );

   string cname [5] = '{"aw", "w", "ar", "b", "r"};
   int    pw    [5] = '{27, 33, 27, 2, 35};

   int n_checks = 0;
   int n_errors = 0;

   // reference model: FIFO of accepted beats per channel
   logic [63:0] mdat [5][4];
   int          mhd  [5];
   int          mcnt [5];

   // test control
   logic        pol_rand [5];
   logic        stim_v   [5];
   logic [63:0] stim_d   [5];
   logic        stim_r   [5];
   logic        hold     [5];
   logic        hs_in    [5];
   logic        hs_out   [5];
   logic        chk_rdy  [5];

   task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] rnd_payload(input int ch);
      logic [63:0] m;
      m = (64'd1 << pw[ch]) - 64'd1;
      return {$urandom, $urandom} & m;
   endfunction

   // One clock: check outputs against the model, drive inputs, predict the edge.
   task automatic tick();
      @(negedge ACLK);
      for (int ch = 0; ch < 5; ch++) begin
         check_value({cname[ch], "_vld"}, {63'd0, obs_vld[ch]}, {63'd0, mcnt[ch] > 0});
         if (mcnt[ch] > 0)
            check_value({cname[ch], "_dat"}, obs_dat[ch], mdat[ch][mhd[ch]]);
         if (chk_rdy[ch])
            check_value({cname[ch], "_rdy"}, {63'd0, obs_rdy[ch]}, {63'd0, mcnt[ch] < 2});
      end
      for (int ch = 0; ch < 5; ch++) begin
         if (pol_rand[ch]) begin
            if (!hold[ch]) begin
               in_v[ch] = ($urandom_range(0, 1) == 1);
               in_d[ch] = rnd_payload(ch);
            end
            out_r[ch] = ($urandom_range(0, 3) != 0);
         end else begin
            in_v[ch]  = stim_v[ch];
            in_d[ch]  = stim_d[ch];
            out_r[ch] = stim_r[ch];
         end
      end
      for (int ch = 0; ch < 5; ch++) begin
         hs_in[ch]  = in_v[ch] & obs_rdy[ch];
         hs_out[ch] = obs_vld[ch] & out_r[ch];
         hold[ch]   = in_v[ch] & ~hs_in[ch];
         if (hs_out[ch] && mcnt[ch] > 0) begin
            mhd[ch]  = (mhd[ch] + 1) % 4;
            mcnt[ch] = mcnt[ch] - 1;
         end
         if (hs_in[ch] && mcnt[ch] < 4) begin
            mdat[ch][(mhd[ch] + mcnt[ch]) % 4] = in_d[ch];
            mcnt[ch] = mcnt[ch] + 1;
         end
      end
   endtask

   // Offer one beat on a channel's input side and wait for it to be taken.
   task automatic send(input int ch, input logic [63:0] d);
      stim_v[ch] = 1'b1;
      stim_d[ch] = d;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (hs_in[ch]) break;
      end
      check_value({cname[ch], "_send_timeout"}, {63'd0, hs_in[ch]}, 64'd1);
      stim_v[ch] = 1'b0;
   endtask

   task automatic quiet_all();
      for (int ch = 0; ch < 5; ch++) begin
         pol_rand[ch] = 1'b0;
         stim_v[ch]   = 1'b0;
         stim_d[ch]   = 64'd0;
         stim_r[ch]   = 1'b1;
      end
   endtask

   // Assert reset mid-cycle: everything must clear without waiting for a clock.
   task automatic do_reset();
      @(negedge ACLK);
      ARESET = 1'b1;
      for (int ch = 0; ch < 5; ch++) begin
         in_v[ch]  = 1'b0;
         out_r[ch] = 1'b0;
         hold[ch]  = 1'b0;
         mhd[ch]   = 0;
         mcnt[ch]  = 0;
      end
      #1;
      for (int ch = 0; ch < 5; ch++) begin
         check_value({cname[ch], "_rst_vld"}, {63'd0, obs_vld[ch]}, 64'd0);
         check_value({cname[ch], "_rst_rdy"}, {63'd0, obs_rdy[ch]}, 64'd0);
         check_value({cname[ch], "_rst_dat"}, obs_dat[ch], 64'd0);
      end
      check_value("rst_burst_err", {63'd0, burst_err}, 64'd0);
      repeat (2) @(negedge ACLK);
      ARESET = 1'b0;
      #1;
      check_value("rel_rdy_before_edge", {63'd0, obs_rdy[2]}, 64'd0);
   endtask

   // Back-to-back beats with the output side always ready.
   task automatic stream(input int ch);
      int ins, outs;
      ins = 0;
      outs = 0;
      quiet_all();
      for (int t = 0; t < 17; t++) begin
         stim_v[ch] = (t < 16);
         stim_d[ch] = rnd_payload(ch);
         tick();
         if (t == 1) check_value({cname[ch], "_stream_first_lat"}, {63'd0, obs_vld[ch]}, 64'd1);
         ins  += int'(hs_in[ch]);
         if (t >= 1) outs += int'(hs_out[ch]);
      end
      tick();
      check_value({cname[ch], "_stream_in"}, 64'(ins), 64'd16);
      check_value({cname[ch], "_stream_out"}, 64'(outs), 64'd16);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout got=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int b, outs, nb_in, nb_out;
      logic saw_low;
      for (int ch = 0; ch < 5; ch++) begin
         in_v[ch] = 1'b0; in_d[ch] = 64'd0; out_r[ch] = 1'b0;
         hold[ch] = 1'b0; mhd[ch] = 0; mcnt[ch] = 0;
`ifdef AXI4_SLICE_BURST_CHECK_EN
         chk_rdy[ch] = (ch >= 2);
`else
         chk_rdy[ch] = 1'b1;
`endif
      end
      quiet_all();
      do_reset();

      // streaming
`ifndef AXI4_SLICE_BURST_CHECK_EN
      stream(0);
`endif
      stream(2);

      // randomized traffic on all channels, then drain
      for (int ch = 0; ch < 5; ch++) pol_rand[ch] = 1'b1;
      repeat (300) tick();
      quiet_all();
      repeat (6) tick();

      // R backpressure: output side stalled for 5 cycles during a 4-beat burst
      quiet_all();
      stim_r[4] = 1'b0;
      b = 0; outs = 0; saw_low = 1'b0;
      for (int t = 0; t < 20; t++) begin
         stim_r[4] = (t >= 5);
         stim_v[4] = (b < 4);
         stim_d[4] = (64'(b + 1) << 3) | ((b == 3) ? 64'd1 : 64'd0);
         tick();
         if (!obs_rdy[4]) saw_low = 1'b1;
         if (hs_in[4]) b++;
         outs += int'(hs_out[4]);
      end
      check_value("r_bp_ready_dropped", {63'd0, saw_low}, 64'd1);
      check_value("r_bp_delivered", 64'(outs), 64'd4);

      // B with READY toggling every cycle: occupancy from observed handshakes
      quiet_all();
      nb_in = 0; nb_out = 0;
      stim_v[3] = 1'b1;
      stim_d[3] = rnd_payload(3);
      for (int t = 0; t < 30; t++) begin
         stim_r[3] = t[0];
         tick();
         nb_in  += int'(hs_in[3]);
         nb_out += int'(hs_out[3]);
         if (hs_in[3]) stim_d[3] = rnd_payload(3);
         check_value("b_occupancy_le2", {63'd0, (nb_in - nb_out) <= 2}, 64'd1);
      end
      stim_v[3] = 1'b0;
      stim_r[3] = 1'b1;
      repeat (4) tick();

      // reset with two W beats buffered
      quiet_all();
      stim_r[1] = 1'b0;
`ifdef AXI4_SLICE_BURST_CHECK_EN
      send(0, 64'd1 << 3);
`endif
      send(1, rnd_payload(1));
      send(1, rnd_payload(1));
      tick();
      check_value("w_buffered_vld", {63'd0, obs_vld[1]}, 64'd1);
      do_reset();
      stim_r[1] = 1'b1;
      repeat (4) tick();

`ifdef AXI4_SLICE_BURST_CHECK_EN
      // gating: W offered before any AW stays blocked
      do_reset();
      quiet_all();
      stim_v[1] = 1'b1;
      stim_d[1] = 64'd1;
      for (int t = 0; t < 3; t++) begin
         tick();
         check_value("gate_w_blocked", {63'd0, obs_rdy[1]}, 64'd0);
      end
      send(0, 64'd0);
      @(posedge ACLK); #1;
      check_value("gate_w_open", {63'd0, s_WREADY}, 64'd1);
      tick();
      stim_v[1] = 1'b0;
      for (int i = 0; i < 4; i++) send(0, rnd_payload(0));
      @(posedge ACLK); #1;
      check_value("gate_aw_full", {63'd0, s_AWREADY}, 64'd0);

      // checker: matching burst then a short one
      do_reset();
      quiet_all();
      send(0, (64'h1234 << 11) | (64'd3 << 3) | 64'd2);
      for (int i = 0; i < 4; i++) send(1, (rnd_payload(1) & ~64'd1) | ((i == 3) ? 64'd1 : 64'd0));
      repeat (3) tick();
      check_value("berr_ok", {63'd0, burst_err}, 64'd0);
      send(0, (64'h5678 << 11) | (64'd3 << 3) | 64'd2);
      for (int i = 0; i < 3; i++) send(1, (rnd_payload(1) & ~64'd1) | ((i == 2) ? 64'd1 : 64'd0));
      tick();
      check_value("berr_set", {63'd0, burst_err}, 64'd1);
      send(0, 64'd0);
      send(1, 64'd1);
      repeat (3) tick();
      check_value("berr_sticky", {63'd0, burst_err}, 64'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
